pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 140 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer pipeline stage with flush and optional performance counters.
// Define PIPE_STAGE_PERF_EN to build the stall/bubble counters; otherwise they read 0.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// ONE   | head valid
// FULL  | head and skid valid, in_ready=0
module pipe_stage_buf #(
   parameter int                DATA_W    = 64,
   parameter logic [DATA_W-1:0] NOP_VALUE = '0,
   parameter int                CNT_W     = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   input  logic              perf_clr,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready_q;
   logic              accept, consume;

   assign in_ready = in_ready_q;
   assign accept   = in_valid && in_ready_q;
   assign consume  = out_valid && out_ready;

   // in_ready is registered from the next state so it never depends on out_ready
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= EMPTY;
         head_q     <= NOP_VALUE;
         skid_q     <= NOP_VALUE;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != FULL);
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         head_d  = NOP_VALUE;
         skid_d  = NOP_VALUE;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  head_d  = in_data;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  head_d = in_data;
               end else if (accept) begin
                  state_d = FULL;
                  skid_d  = in_data;
               end else if (consume) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (consume) begin
                  state_d = ONE;
                  head_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      out_valid = 1'b0;
      occupancy = 2'd0;
      case (state_q)
         ONE: begin
            out_valid = 1'b1;
            occupancy = 2'd1;
         end
         FULL: begin
            out_valid = 1'b1;
            occupancy = 2'd2;
         end
         default: begin
            out_valid = 1'b0;
            occupancy = 2'd0;
         end
      endcase
      out_data = out_valid ? head_q : NOP_VALUE;
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_q, bubble_q;

   // counters saturate at all-ones; perf_clr wins over an increment
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else if (perf_clr) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
         if (out_ready && !out_valid && (bubble_q != '1))
            bubble_q <= bubble_q + CNT_W'(1);
      end
   end

   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;
`else
   logic unused_perf_clr;
   assign unused_perf_clr = perf_clr;
   assign stall_cnt       = '0;
   assign bubble_cnt      = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: vector table plus scoreboard queue,
// with hand-written counter-saturation and mid-operation reset sequences.
module tb_pipe_stage_buf;

   localparam int          DATA_W = 64;
   localparam int          CNT_W  = 4;
   localparam logic [63:0] NOP    = 64'h0000_0000_DEAD_BEEF;
`ifdef PIPE_STAGE_PERF_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   logic              CLK = 1'b0;
   logic              nRST = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              flush = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
   logic              perf_clr = 1'b0;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  bubble_cnt;

   pipe_stage_buf #(.DATA_W(DATA_W), .NOP_VALUE(NOP), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy),
      .perf_clr(perf_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        iv;
      logic [63:0] id;
      logic        ordy;
      logic        fl;
      int          occ;
   } vec_t;

   vec_t        vecs[25];
   logic [63:0] sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          exp_stall = 0;
   int          exp_bubble = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // inputs go on just after a rising edge; outputs are sampled at the falling edge
   task automatic step(input logic iv, input logic [63:0] id, input logic ordy,
                       input logic fl, input logic pc, input int occ);
      logic        m_valid, m_ready;
      logic [63:0] exp;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      perf_clr  = pc;
      @(negedge CLK);
      m_valid = (sb.size() != 0);
      m_ready = (sb.size() < 2);
      if (occ >= 0) check("occupancy", 64'(occupancy), 64'(occ));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("in_ready", 64'(in_ready), 64'(m_ready));
      if (!m_valid) check("nop_data", out_data, NOP);
      check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      check("bubble_cnt", 64'(bubble_cnt), 64'(exp_bubble));
      if (m_valid && ordy) begin
         exp = sb.pop_front();
         check("out_data", out_data, exp);
      end
      if (fl) sb.delete();
      else if (iv && m_ready) sb.push_back(id);
      if (PERF_EN) begin
         if (pc) begin
            exp_stall  = 0;
            exp_bubble = 0;
         end else begin
            if (m_valid && !ordy && exp_stall < 15) exp_stall++;
            if (!m_valid && ordy && exp_bubble < 15) exp_bubble++;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      check({tag, "_occupancy"}, 64'(occupancy), 64'(0));
      check({tag, "_out_data"}, out_data, NOP);
      check({tag, "_stall"}, 64'(stall_cnt), 64'(0));
      check({tag, "_bubble"}, 64'(bubble_cnt), 64'(0));
   endtask

   initial begin
      // back-to-back flow
      vecs[0]  = '{1'b1, 64'hA,  1'b1, 1'b0, 0};
      vecs[1]  = '{1'b1, 64'hB,  1'b1, 1'b0, 1};
      vecs[2]  = '{1'b1, 64'hC,  1'b1, 1'b0, 1};
      vecs[3]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1};
      vecs[4]  = '{1'b0, 64'h0,  1'b1, 1'b0, 0};
      // skid fill, blocked offer, drain
      vecs[5]  = '{1'b1, 64'h11, 1'b0, 1'b0, 0};
      vecs[6]  = '{1'b1, 64'h22, 1'b0, 1'b0, 1};
      vecs[7]  = '{1'b1, 64'h99, 1'b0, 1'b0, 2};
      vecs[8]  = '{1'b0, 64'h0,  1'b1, 1'b0, 2};
      vecs[9]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1};
      vecs[10] = '{1'b0, 64'h0,  1'b0, 1'b0, 0};
      // flush collision from FULL
      vecs[11] = '{1'b1, 64'h44, 1'b0, 1'b0, 0};
      vecs[12] = '{1'b1, 64'h55, 1'b0, 1'b0, 1};
      vecs[13] = '{1'b1, 64'h33, 1'b0, 1'b1, 2};
      vecs[14] = '{1'b0, 64'h0,  1'b1, 1'b0, 0};
      // flush with same-cycle consume and accept in ONE
      vecs[15] = '{1'b1, 64'h66, 1'b0, 1'b0, 0};
      vecs[16] = '{1'b1, 64'h77, 1'b1, 1'b1, 1};
      vecs[17] = '{1'b0, 64'h0,  1'b0, 1'b0, 0};
      // ONE with accept and consume together, then hold
      vecs[18] = '{1'b1, 64'h88, 1'b0, 1'b0, 0};
      vecs[19] = '{1'b1, 64'h89, 1'b1, 1'b0, 1};
      vecs[20] = '{1'b1, 64'h8A, 1'b1, 1'b0, 1};
      vecs[21] = '{1'b0, 64'h0,  1'b0, 1'b0, 1};
      vecs[22] = '{1'b0, 64'h0,  1'b0, 1'b0, 1};
      vecs[23] = '{1'b0, 64'h0,  1'b1, 1'b0, 1};
      vecs[24] = '{1'b0, 64'h0,  1'b1, 1'b0, 0};

      #12;
      check_reset_values("por");
      nRST = 1'b1;
      @(posedge CLK);
      #1;

      foreach (vecs[i]) step(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl, 1'b0, vecs[i].occ);

      // counter saturation and clear
      step(1'b1, 64'hC0, 1'b0, 1'b0, 1'b1, 0);
      for (int k = 0; k < 20; k++) step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1);
      check("stall_sat", 64'(stall_cnt), PERF_EN ? 64'd15 : 64'd0);
      check("bubble_hold", 64'(bubble_cnt), 64'd0);
      step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1);
      check("stall_clr", 64'(stall_cnt), 64'd0);
      step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1);

      // reset mid-operation from FULL, then accept on the first edge after release
      step(1'b1, 64'hD1, 1'b0, 1'b0, 1'b0, 0);
      step(1'b1, 64'hD2, 1'b0, 1'b0, 1'b0, 1);
      in_valid = 1'b0;
      check("full_before_rst", 64'(occupancy), 64'd2);
      #1 nRST = 1'b0;
      #1 check_reset_values("mid");
      #1 nRST = 1'b1;
      sb.delete();
      exp_stall  = 0;
      exp_bubble = 0;
      step(1'b1, 64'hE1, 1'b1, 1'b0, 1'b0, 0);
      step(1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1);
      step(1'b0, 64'h0,  1'b0, 1'b0, 1'b0, 0);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
